// File: rtl/bitstream_unpack_if.sv
// Word-input and field-request bus for the bit-level stream reader.
interface bitstream_unpack_if #(
  parameter int DW = 32,
  parameter int LW = 6
);
  logic          flush;
  logic          iwvalid;
  logic          iwready;
  logic [DW-1:0] iwdata;
  logic          rreq;
  logic          ralign;
  logic [LW-1:0] rlen;
  logic          rack;
  logic          ovalid;
  logic [DW-1:0] odata;
  logic [DW-1:0] peek;
  logic [6:0]    count;

  modport master (
    output flush, iwvalid, iwdata, rreq, ralign, rlen,
    input  iwready, rack, ovalid, odata, peek, count
  );

  modport slave (
    input  flush, iwvalid, iwdata, rreq, ralign, rlen,
    output iwready, rack, ovalid, odata, peek, count
  );
endinterface

// File: rtl/bitstream_unpack.sv
// LSB-first bit reader: buffers packed 32-bit words, returns 0..32-bit fields
// on request, and can discard bits up to the next byte boundary.
module bitstream_unpack #(
  parameter int DW = 32,
  parameter int LW = 6
) (
  input logic               clk,
  input logic               rst_n,
  bitstream_unpack_if.slave bs
);
  localparam logic [DW-1:0] ONES = '1;

  logic [2*DW-1:0] bits_q;
  logic [6:0]      count_q;
  logic [2:0]      phase_q;
  logic            ovalid_q;
  logic [DW-1:0]   odata_q;

  logic [2:0]      pad;
  logic [6:0]      need;
  logic [6:0]      c;
  logic [6:0]      shamt;
  logic            rack;
  logic            iwready;
  logic            accept;
  logic [DW-1:0]   mask;

  always_comb begin
    pad     = 3'd0 - phase_q;
    need    = bs.ralign ? {4'd0, pad} : 7'(bs.rlen);
    rack    = bs.rreq && !bs.flush && (count_q >= need);
    iwready = rst_n && (count_q <= 7'd32);
    accept  = bs.iwvalid && iwready && !bs.flush;
    c       = rack ? need : '0;
    shamt   = count_q - c;
    // Shifting by the full width yields zero, so rlen=0 gives an empty mask.
    mask    = ONES >> (7'd32 - 7'(bs.rlen));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q   <= '0;
      count_q  <= '0;
      phase_q  <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else if (bs.flush) begin
      bits_q   <= '0;
      count_q  <= '0;
      phase_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      // Consume first, then append the new word just above the surviving bits.
      bits_q   <= (bits_q >> c)
                | (accept ? ({{DW{1'b0}}, bs.iwdata} << shamt) : '0);
      count_q  <= count_q - c + (accept ? 7'd32 : 7'd0);
      phase_q  <= phase_q + c[2:0];
      ovalid_q <= rack && !bs.ralign;
      if (rack && !bs.ralign)
        odata_q <= bits_q[DW-1:0] & mask;
    end
  end

  assign bs.rack    = rack;
  assign bs.iwready = iwready;
  assign bs.ovalid  = ovalid_q;
  assign bs.odata   = odata_q;
  assign bs.peek    = bits_q[DW-1:0];
  assign bs.count   = count_q;

  logic          pend_q;
  logic [LW-1:0] rlen_q;
  logic          ralign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      rlen_q   <= '0;
      ralign_q <= 1'b0;
    end else begin
      pend_q   <= bs.rreq && !rack && !bs.flush;
      rlen_q   <= bs.rlen;
      ralign_q <= bs.ralign;
    end
  end

  a_rlen_range: assert property (@(posedge clk) disable iff (!rst_n)
    !(bs.rreq && (7'(bs.rlen) > 7'd32)))
    else $fatal(1, "bitstream_unpack: rlen %0d exceeds 32", bs.rlen);

  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (pend_q && bs.rreq) |-> (bs.rlen == rlen_q && bs.ralign == ralign_q))
    else $warning("bitstream_unpack: request changed while stalled");
endmodule
